dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

- Two-port arbiter and sequencer in front of the 256 x 8 synchronous data memory.
- Port 0 belongs to the pipeline MEM stage. Port 1 belongs to the debug/loader path.
- Grants one access at a time and drives the memory's write-enable, read-enable, address and write-data with registered signals.
- Returns read data to the owning port with a single-cycle valid strobe.

## Interface
Parameters:
- `AW`, 8: address width; memory depth is 2^AW.
- `DW`, 8: data width.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request, port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  AW  access address.
- `wdata0` / `wdata1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  one-cycle grant pulse.
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data-valid pulse.
- `rdata`  out  DW  read data; equals `mem_rd` while either `rvalid` is high, else 0.
- `busy`  out  1  high in ISSUE and RESP.
- `mem_we`, `mem_re`  out  1  registered memory write and read enables.
- `mem_a`  out  AW  registered memory address.
- `mem_wd`  out  DW  registered memory write data.
- `mem_rd`  in  DW  memory read data, registered inside the memory.

## Operation
FSM states:
- IDLE: sample `req0`/`req1`. With no request, stay in IDLE. With any request, pick a winner, load `mem_*` from the winner's fields, set `mem_we = we` and `mem_re = !we`, pulse `gnt` for the winner, record the owner and operation, and go to ISSUE.
- ISSUE: the memory performs the access on the closing edge. On that edge, clear `mem_we`/`mem_re` and `gnt`. Go to RESP for a read, IDLE for a write.
- RESP: hold `rvalid` high for the owner and drive `rdata = mem_rd`. Go to IDLE.

Requester rules:
- Hold `req`, `we`, `addr` and `wdata` stable until it sees its `gnt`.
- Deassert `req` in the `gnt` cycle unless it wants another access.
- A `req` still high in a later IDLE cycle is treated as a new access.

Arbitration and data rules:
- `req` is ignored in ISSUE and RESP. No queueing, no back-to-back overlap.
- Arbitration by default is fixed priority: port 0 wins a simultaneous request.
- `mem_a` and `mem_wd` hold their last values when idle. Only the enables are cleared.
- The full AW-bit address range is legal, with no wrap or range check.

Reset (asynchronous, any state):
- Returns the FSM to IDLE.
- Drives all outputs to 0: `gnt*`, `rvalid*`, `rdata`, `busy`, `mem_we`, `mem_re`, `mem_a`, `mem_wd`.
- Drops any in-flight access. A write in ISSUE is not completed, because `mem_we` falls asynchronously.

## Timing
- Edge E0: IDLE samples the request. After E0: `gnt` = 1, `mem_*` valid, `busy` = 1.
- Edge E1: the memory samples the access. After E1:
  - a write has landed and the state is IDLE;
  - a read gives `rvalid` = 1 and `rdata` = mem[addr].
- Edge E2 (reads only): back to IDLE.
- Write latency: 2 cycles, request sample to next sample.
- Read latency: data valid 1 cycle after `gnt`; the next request is sampled 3 cycles after the previous sample.
- `rvalid` never asserts for writes. `gnt0` and `gnt1` are never high together.

## Configuration
Macro `DMEM_ARB_RR_EN` selects the tie-break for simultaneous requests:
- Defined: round-robin. A 1-bit last-grant pointer is updated on every grant and resets to 1, so port 0 wins the first tie. Each later tie goes to the port not granted last.
- Undefined: fixed priority, port 0 always wins. No pointer register exists.

## Test plan
- Port-0 write, then read: write addr 0x10 data 0xA5, then read 0x10. Expect `gnt0` pulses, `mem_we` high for exactly one cycle, then `rvalid0` = 1 with `rdata` = 0xA5 exactly 1 cycle after the read `gnt0`.
- Simultaneous requests, both reads: port 0 reads 0x01 and port 1 reads 0x02, held continuously.
  - Without the macro: `gnt0` every grant, `gnt1` never.
  - With `DMEM_ARB_RR_EN`: grants alternate 0, 1, 0, 1.
- Busy blocking: raise `req1` one cycle after `gnt0` for a read. Expect no `gnt1` until RESP has ended; `gnt1` follows on the next IDLE sample.
- Address boundary: write 0xFF to addr 0xFF and 0x11 to addr 0x00, then read both back. Expect exact data with no aliasing.
- Reset mid-write: assert `rst_n` low during ISSUE. Expect all outputs 0 immediately and the FSM in IDLE after release. A subsequent read of that address returns 0x00.
- Back-to-back writes from port 1 holding `req1` high: expect one `gnt1` every 2 cycles and `mem_we` never high in two consecutive cycles.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for dmem_arbiter.
// slave = arbiter view, master = requesters plus the memory model.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_we, mem_re, mem_a, mem_wd
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
           mem_we, mem_re, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a synchronous data memory: one access at a time.
// Tie-break: fixed priority to port 0, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]    state;
  logic          owner;
  logic          rd_op;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;

  logic          any_req;
  logic          win1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign any_req = bus.req0 | bus.req1;

`ifdef DMEM_ARB_RR_EN
  // last1 = 1 means port 1 took the previous grant; reset value lets port 0 win the first tie
  logic last1;

  assign win1 = bus.req1 & (~bus.req0 | ~last1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last1 <= 1'b1;
    else if (state == IDLE && any_req)
      last1 <= win1;
  end
`else
  assign win1 = bus.req1 & ~bus.req0;
`endif

  assign sel_we    = win1 ? bus.we1    : bus.we0;
  assign sel_addr  = win1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = win1 ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rd_op   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_a  <= sel_addr;
            mem_wd <= sel_wdata;
            mem_we <= sel_we;
            mem_re <= ~sel_we;
            gnt0   <= ~win1;
            gnt1   <= win1;
            owner  <= win1;
            rd_op  <= ~sel_we;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // memory takes the access on this edge; address/data stay put
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (rd_op) begin
            rvalid0 <= ~owner;
            rvalid1 <= owner;
            state   <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata   = (rvalid0 | rvalid1) ? bus.mem_rd : '0;
  assign bus.busy    = (state != IDLE);
  assign bus.mem_we  = mem_we;
  assign bus.mem_re  = mem_re;
  assign bus.mem_a   = mem_a;
  assign bus.mem_wd  = mem_wd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected grants/read data,
// a negedge monitor pops and compares whenever the DUT strobes gnt or rvalid.
module tb_dmem_arbiter;
  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256 x 8 synchronous memory, read data registered
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a] <= bus.mem_wd;
    if (bus.mem_re) bus.mem_rd <= mem[bus.mem_a];
  end

  typedef struct { int port; logic [7:0] data; } rd_t;
  int  exp_gnt [$];
  rd_t exp_rd  [$];

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.gnt0 | bus.gnt1) begin
      chk("gnt_exclusive", int'(bus.gnt0 & bus.gnt1), 0);
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
      else chk("gnt_port", bus.gnt1 ? 1 : 0, exp_gnt.pop_front());
    end
    if (bus.rvalid0 | bus.rvalid1) begin
      if (exp_rd.size() == 0) chk("rvalid_unexpected", 1, 0);
      else begin
        rd_t e;
        e = exp_rd.pop_front();
        chk("rvalid_port", bus.rvalid1 ? 1 : 0, e.port);
        chk("rdata", int'(bus.rdata), int'(e.data));
      end
    end
    if (bus.mem_we) begin
      chk("mem_we_consecutive", int'(prev_we), 0);
      we_cnt++;
    end
    prev_we = bus.mem_we;
  end

  function automatic bit gnt_of(input int p);
    return (p == 1) ? bus.gnt1 : bus.gnt0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"},    int'(bus.gnt0), 0);
    chk({tag, "_gnt1"},    int'(bus.gnt1), 0);
    chk({tag, "_rvalid0"}, int'(bus.rvalid0), 0);
    chk({tag, "_rvalid1"}, int'(bus.rvalid1), 0);
    chk({tag, "_rdata"},   int'(bus.rdata), 0);
    chk({tag, "_busy"},    int'(bus.busy), 0);
    chk({tag, "_mem_we"},  int'(bus.mem_we), 0);
    chk({tag, "_mem_re"},  int'(bus.mem_re), 0);
    chk({tag, "_mem_a"},   int'(bus.mem_a), 0);
    chk({tag, "_mem_wd"},  int'(bus.mem_wd), 0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle showing the grant.
  // d is write data for writes, expected read data for reads.
  task automatic access(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    int n;
    exp_gnt.push_back(p);
    if (!w) exp_rd.push_back('{p, d});
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!gnt_of(p) && n < 30);
    if (!gnt_of(p)) chk("gnt_timeout", 0, 1);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, last_cyc, cyc;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // port-0 write then read, mem_we exactly one cycle, data 1 cycle after gnt
    we_cnt = 0;
    access(0, 1'b1, 8'h10, 8'hA5);
    repeat (3) @(posedge clk);
    #1;
    chk("wr_we_pulse_count", we_cnt, 1);
    access(0, 1'b0, 8'h10, 8'hA5);
    @(posedge clk); #1;
    chk("rd_latency_rvalid0", int'(bus.rvalid0), 1);
    chk("rd_latency_rdata", int'(bus.rdata), 8'hA5);

    // preload for the simultaneous-read test (last grant is port 1 afterwards)
    access(1, 1'b1, 8'h01, 8'h3C);
    access(1, 1'b1, 8'h02, 8'hC3);

    // simultaneous reads held continuously
`ifdef DMEM_ARB_RR_EN
    exp_gnt.push_back(0); exp_rd.push_back('{0, 8'h3C});
    exp_gnt.push_back(1); exp_rd.push_back('{1, 8'hC3});
    exp_gnt.push_back(0); exp_rd.push_back('{0, 8'h3C});
    exp_gnt.push_back(1); exp_rd.push_back('{1, 8'hC3});
`else
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(0); exp_rd.push_back('{0, 8'h3C});
    end
`endif
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h01;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h02;
    k = 0; n = 0;
    while (k < 4 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.gnt0 | bus.gnt1) k++;
    end
    chk("tie_grant_count", k, 4);
    bus.req0 = 0; bus.req1 = 0;

    // busy blocking: req1 raised one cycle after gnt0 waits for RESP to end
    access(0, 1'b0, 8'h10, 8'hA5);
    @(posedge clk); #1;
    exp_gnt.push_back(1); exp_rd.push_back('{1, 8'hC3});
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h02;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.gnt1 && n < 20);
    chk("busy_block_gnt1_delay", n, 2);
    bus.req1 = 0;

    // address boundary
    access(0, 1'b1, 8'hFF, 8'hFF);
    access(0, 1'b1, 8'h00, 8'h11);
    access(1, 1'b0, 8'hFF, 8'hFF);
    access(1, 1'b0, 8'h00, 8'h11);

    // back-to-back port-1 writes with req1 held
    for (int i = 0; i < 4; i++) exp_gnt.push_back(1);
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h80; bus.wdata1 = 8'h40;
    k = 0; n = 0; cyc = 0; last_cyc = 0;
    while (k < 4 && n < 60) begin
      @(posedge clk); #1;
      n++; cyc++;
      if (bus.gnt1) begin
        if (k > 0) chk("b2b_gnt_interval", cyc - last_cyc, 2);
        last_cyc = cyc;
        k++;
        bus.addr1  = 8'h80 + 8'(k);
        bus.wdata1 = 8'h40 + 8'(k);
        if (k == 4) bus.req1 = 0;
      end
    end
    chk("b2b_grant_count", k, 4);
    bus.req1 = 0;
    access(0, 1'b0, 8'h82, 8'h42);
    access(0, 1'b0, 8'h83, 8'h43);

    // reset during ISSUE of a write
    access(0, 1'b1, 8'h33, 8'h77);
    @(negedge clk); #1;
    chk("pre_reset_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", int'(bus.busy), 0);
    access(0, 1'b0, 8'h33, 8'h00);
    access(1, 1'b0, 8'h10, 8'hA5);

    repeat (6) @(posedge clk);
    #1;
    chk("gnt_queue_drained", exp_gnt.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
